// File: rtl/esp_arb_pkg.sv
// esp_arb_pkg: shared ESP_S codes, printer status values and arbiter state type
package esp_arb_pkg;

    localparam logic [2:0] ESP_S_TRS_IN    = 3'd0;
    localparam logic [2:0] ESP_S_TRS_OUT   = 3'd1;
    localparam logic [2:0] ESP_S_FREHD_IN  = 3'd2;
    localparam logic [2:0] ESP_S_FREHD_OUT = 3'd3;
    localparam logic [2:0] ESP_S_PRINTER   = 3'd4;

    localparam logic [7:0] PRINTER_READY = 8'h30;
    localparam logic [7:0] PRINTER_BUSY  = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

endpackage

// File: rtl/sync_rise.sv
// sync_rise: 2-FF synchronizer for an asynchronous level plus a registered rising-edge pulse
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [2:0] sh;

    // shift the raw level through two sync stages and one history stage; edge is registered
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh   <= '0;
            rise <= 1'b0;
        end else begin
            sh   <= {sh[1:0], d};
            rise <= sh[1] & ~sh[2];
        end
endmodule

// File: rtl/esp_req_arbiter.sv
// esp_req_arbiter: sequences ESP32-serviced port accesses (ESP_REQ pulse, ESP_S, WAIT, posted printer byte, one pending job).
// Optional watchdog enabled by ESP_TIMEOUT_EN. The Z80 WAIT output is named z80_wait because wait is a reserved word.
module esp_req_arbiter
    import esp_arb_pkg::*;
#(
    parameter int REQ_PULSE = 50,
    parameter int TIMEOUT_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_valid,
    input  logic [2:0] sel_kind,
    input  logic [7:0] sel_data,
    input  logic       esp_done,
    output logic       esp_req,
    output logic [2:0] esp_s,
    output logic       z80_wait,
    output logic [7:0] printer_byte,
    output logic [7:0] printer_status,
    output logic       drop_err,
    output logic       timeout_err
);
    if (REQ_PULSE < 1 || REQ_PULSE > 63 || TIMEOUT_W < 2) begin : g_bad_param
        $error("esp_req_arbiter: parameter out of range");
    end

    state_t     state;
    logic [5:0] pulse_cnt;
    logic       pend_valid;
    logic [2:0] pend_kind;
    logic       done_rise, expire, complete, legal, store, launch;
    logic       accept_posted, accept_blocking, next_valid;
    logic [2:0] next_kind;

    sync_rise u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (esp_done),
        .rise (done_rise)
    );

    // a strobe during an active job is queued only into an empty slot, and never a second printer job
    assign legal           = sel_valid && sel_kind <= ESP_S_PRINTER;
    assign store           = legal && state != S_IDLE && !pend_valid &&
                             !(sel_kind == ESP_S_PRINTER && esp_s == ESP_S_PRINTER);
    assign accept_posted   = legal && sel_kind == ESP_S_PRINTER && (state == S_IDLE || store);
    assign accept_blocking = legal && sel_kind != ESP_S_PRINTER && (state == S_IDLE || store);
    assign complete        = state != S_IDLE && (done_rise || expire);
    assign next_valid      = pend_valid || store;
    assign next_kind       = pend_valid ? pend_kind : sel_kind;
    assign launch          = (state == S_IDLE && legal) || (complete && next_valid);

`ifdef ESP_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd;

    assign expire = state != S_IDLE && &wd;

    // watchdog restarts at every job launch and runs while a job is outstanding
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            wd          <= launch ? TIMEOUT_W'(1) : (state != S_IDLE ? wd + 1'b1 : wd);
        end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // job sequencing: strobes are judged against the pre-completion state, then a completion issues the next job
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= S_IDLE;
            esp_req        <= 1'b0;
            esp_s          <= '0;
            z80_wait       <= 1'b0;
            printer_byte   <= '0;
            printer_status <= PRINTER_READY;
            pend_valid     <= 1'b0;
            pend_kind      <= '0;
            pulse_cnt      <= '0;
            drop_err       <= 1'b0;
        end else begin
            drop_err <= sel_valid && !(state == S_IDLE ? legal : store);
            if (accept_posted)
                printer_byte <= sel_data;
            if (complete)
                printer_status <= next_valid && next_kind == ESP_S_PRINTER ? PRINTER_BUSY : PRINTER_READY;
            else if (accept_posted)
                printer_status <= PRINTER_BUSY;
            if (complete)
                z80_wait <= next_valid && next_kind != ESP_S_PRINTER;
            else if (accept_blocking)
                z80_wait <= 1'b1;
            if (complete)
                pend_valid <= 1'b0;
            else if (store) begin
                pend_valid <= 1'b1;
                pend_kind  <= sel_kind;
            end
            if (state == S_IDLE) begin
                if (legal) begin
                    state     <= S_REQ;
                    esp_req   <= 1'b1;
                    esp_s     <= sel_kind;
                    pulse_cnt <= 6'(REQ_PULSE - 1);
                end
            end else if (complete) begin
                // a queued job re-enters REQ with esp_req low for one cycle before its pulse
                esp_req <= 1'b0;
                state   <= next_valid ? S_REQ : S_IDLE;
                if (next_valid)
                    esp_s <= next_kind;
            end else if (state == S_REQ) begin
                if (!esp_req) begin
                    esp_req   <= 1'b1;
                    pulse_cnt <= 6'(REQ_PULSE - 1);
                end else if (pulse_cnt == 0) begin
                    esp_req <= 1'b0;
                    state   <= S_BUSY;
                end else
                    pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
endmodule

// File: tb/tb_esp_req_arbiter.sv
// tb_esp_req_arbiter: directed scenarios plus random strobes/done toggles against a job-level reference model
module tb_esp_req_arbiter;
    localparam int P  = 50;
    localparam int TW = 8;

    logic       clk = 1'b0, rst_n = 1'b0, sel_valid = 1'b0, esp_done = 1'b0;
    logic [2:0] sel_kind = '0;
    logic [7:0] sel_data = '0;
    logic       esp_req, z80_wait, drop_err, timeout_err;
    logic [2:0] esp_s;
    logic [7:0] printer_byte, printer_status;

    int errors = 0, checks = 0, n;

    esp_req_arbiter #(.REQ_PULSE(P), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_kind(sel_kind), .sel_data(sel_data),
        .esp_done(esp_done), .esp_req(esp_req), .esp_s(esp_s), .z80_wait(z80_wait),
        .printer_byte(printer_byte), .printer_status(printer_status), .drop_err(drop_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // reference model: one job in service, a queue of at most one waiting job, done level history
    bit         m_busy, m_gap, m_wait, m_drop, m_tout;
    int         m_left, m_age;
    logic [2:0] m_cur;
    logic [7:0] m_byte, m_stat;
    logic [2:0] m_pq[$];
    bit         lv[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_wait = 0; m_drop = 0; m_tout = 0;
        m_left = 0; m_age = 0; m_cur = 0; m_byte = 0; m_stat = 8'h30;
        m_pq.delete();
        lv = '{0, 0, 0, 0, 0};
    endtask

    // one clock edge of behaviour: done is noticed 3 edges after first being sampled high
    task automatic model_edge();
        bit rise, expd, cmpl, was_busy;
        lv.push_back(esp_done);
        void'(lv.pop_front());
        rise = lv[1] && !lv[0];
        expd = 0;
        was_busy = m_busy;
`ifdef ESP_TIMEOUT_EN
        if (m_busy) begin
            m_age++;
            expd = m_age == (1 << TW) - 1;
        end
`endif
        cmpl = m_busy && (rise || expd);
        m_drop = 0;
        m_tout = expd;
        if (sel_valid) begin
            if (sel_kind > 4) m_drop = 1;
            else if (!m_busy) begin
                m_busy = 1; m_cur = sel_kind; m_left = P; m_gap = 0; m_age = 0;
                if (sel_kind < 4) m_wait = 1;
                else begin m_byte = sel_data; m_stat = 8'hF0; end
            end else if (m_pq.size() == 0 && !(sel_kind == 4 && m_cur == 4)) begin
                m_pq.push_back(sel_kind);
                if (sel_kind < 4) m_wait = 1;
                else begin m_byte = sel_data; m_stat = 8'hF0; end
            end else m_drop = 1;
        end
        if (cmpl) begin
            if (m_cur < 4) m_wait = 0;
            else m_stat = 8'h30;
            if (m_pq.size() != 0) begin
                m_cur = m_pq.pop_front();
                m_gap = 1; m_left = 0; m_age = 0;
                if (m_cur < 4) m_wait = 1;
            end else begin
                m_busy = 0; m_left = 0; m_gap = 0;
            end
        end else if (was_busy) begin
            if (m_gap) begin m_gap = 0; m_left = P; end
            else if (m_left > 0) m_left--;
        end
    endtask

    task automatic compare();
        check("esp_req", esp_req, m_busy && !m_gap && m_left > 0);
        check("esp_s", esp_s, m_cur);
        check("wait", z80_wait, m_wait);
        check("printer_byte", printer_byte, m_byte);
        check("printer_status", printer_status, m_stat);
        check("drop_err", drop_err, m_drop);
        check("timeout_err", timeout_err, m_tout);
    endtask

    task automatic step(input bit v, input logic [2:0] k, input logic [7:0] d, input bit dn);
        sel_valid = v; sel_kind = k; sel_data = d; esp_done = dn;
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1 compare();
    endtask

    task automatic run(input int cyc, input bit dn);
        for (int i = 0; i < cyc; i++) step(0, 0, 0, dn);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare();
        check("rst_status", printer_status, 8'h30);
        check("rst_req", esp_req, 0);
        rst_n = 1;
        // kind 0: pulse length and done-to-wait latency
        step(1, 0, 0, 0);
        n = esp_req;
        for (int i = 0; i < 99; i++) begin step(0, 0, 0, 0); n += esp_req; end
        check("pulse_len", n, P);
        check("s1_wait_held", z80_wait, 1);
        step(0, 0, 0, 1);
        n = 1;
        while (z80_wait && n < 20) begin step(0, 0, 0, 1); n++; end
        check("done_to_wait", n, 4);
        run(5, 0);
        // posted printer byte
        step(1, 4, 8'h41, 0);
        check("s2_wait", z80_wait, 0);
        check("s2_byte", printer_byte, 8'h41);
        check("s2_busy", printer_status, 8'hF0);
        run(10, 0);
        step(0, 0, 0, 1);
        run(5, 1);
        check("s2_ready", printer_status, 8'h30);
        run(3, 0);
        // blocking job queued behind printer job
        step(1, 4, 8'h55, 0);
        run(3, 0);
        step(1, 2, 0, 0);
        check("s3_wait", z80_wait, 1);
        check("s3_esp_s_first", esp_s, 4);
        run(60, 0);
        step(0, 0, 0, 1);
        run(3, 1);
        check("s3_gap", esp_req, 0);
        check("s3_esp_s_second", esp_s, 2);
        run(1, 1);
        check("s3_rerise", esp_req, 1);
        run(60, 0);
        step(0, 0, 0, 1);
        run(5, 1);
        check("s3_wait_fall", z80_wait, 0);
        run(3, 0);
        // drops: extra printer strobes while printing, illegal code in IDLE
        step(1, 4, 8'h61, 0);
        step(1, 4, 8'h62, 0);
        check("s4_drop", drop_err, 1);
        check("s4_byte", printer_byte, 8'h61);
        run(5, 0);
        step(0, 0, 0, 1);
        run(5, 1);
        step(1, 7, 8'h00, 0);
        check("s4_drop_idle", drop_err, 1);
        check("s4_idle_req", esp_req, 0);
        run(3, 0);
`ifdef ESP_TIMEOUT_EN
        step(1, 1, 0, 0);
        n = 1;
        while (!timeout_err && n < 400) begin step(0, 0, 0, 0); n++; end
        check("timeout_cycle", n, 256);
        check("timeout_wait", z80_wait, 0);
        run(3, 0);
`endif
        // async reset while BUSY with a pending job
        step(1, 4, 8'h77, 0);
        step(1, 0, 0, 0);
        run(60, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare();
        check("ar_status", printer_status, 8'h30);
        check("ar_wait", z80_wait, 0);
        run(2, 0);
        rst_n = 1;
        step(0, 0, 0, 1);
        run(6, 1);
        check("ar_done_ignored", esp_req, 0);
        run(3, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic dn;
            dn = esp_done;
            if ($urandom_range(0, 39) == 0) dn = ~dn;
            step($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), 8'($urandom), dn);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
